pipeline_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_load_use_cmp.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard sequencer and its helpers.
package hazard_pkg;

    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned STATE_W     = 2;
    localparam int unsigned WAIT_CNT_W  = 8;
    localparam int unsigned FLUSH_CNT_W = 3;
    localparam int unsigned PERF_CNT_W  = 32;

    typedef enum logic [STATE_W-1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_FLUSH    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use dependence check between the IF/ID sources and the
// destination of a load sitting in ID/EX.
module hazard_load_use_cmp
    import hazard_pkg::*;
(
    input  logic                 i_if_id_valid,
    input  logic [REG_IDX_W-1:0] i_if_id_rs1,
    input  logic [REG_IDX_W-1:0] i_if_id_rs2,
    input  logic                 i_if_id_use_rs1,
    input  logic                 i_if_id_use_rs2,
    input  logic                 i_id_ex_valid,
    input  logic                 i_id_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_id_ex_rd,
    output logic                 o_hit
);

    logic w_load_live;
    logic w_rs1_dep;
    logic w_rs2_dep;

    // x0 is never a real producer, so a load to x0 cannot create a dependence
    assign w_load_live = i_if_id_valid && i_id_ex_valid && i_id_ex_mem_read &&
                         (i_id_ex_rd != '0);
    assign w_rs1_dep   = i_if_id_use_rs1 && (i_if_id_rs1 == i_id_ex_rd);
    assign w_rs2_dep   = i_if_id_use_rs2 && (i_if_id_rs2 == i_id_ex_rd);
    assign o_hit       = w_load_live && (w_rs1_dep || w_rs2_dep);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: memory freeze, redirect flush and load-use bubble.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_id_valid,
    input  logic [REG_IDX_W-1:0]  if_id_rs1,
    input  logic [REG_IDX_W-1:0]  if_id_rs2,
    input  logic                  if_id_use_rs1,
    input  logic                  if_id_use_rs2,
    input  logic                  id_ex_valid,
    input  logic                  id_ex_mem_read,
    input  logic [REG_IDX_W-1:0]  id_ex_rd,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  hazard_stall,
    output logic                  hazard_flush,
    output logic                  mem_freeze,
    output logic                  mem_timeout,
    output logic [STATE_W-1:0]    ctrl_state,
    output logic [PERF_CNT_W-1:0] perf_stall_cycles,
    output logic [PERF_CNT_W-1:0] perf_flush_events
);

    localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST  = WAIT_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hz_state_e              r_state;
    hz_state_e              w_state_next;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [FLUSH_CNT_W-1:0] w_flush_cnt_inc;
    logic                   r_mem_timeout;

    logic w_in_run;
    logic w_in_wait;
    logic w_in_flush;
    logic w_load_use_hit;
    logic w_timeout;
    logic w_freeze;
    logic w_redirect;
    logic w_load_use;

    hazard_load_use_cmp u_load_use_cmp (
        .i_if_id_valid    (if_id_valid),
        .i_if_id_rs1      (if_id_rs1),
        .i_if_id_rs2      (if_id_rs2),
        .i_if_id_use_rs1  (if_id_use_rs1),
        .i_if_id_use_rs2  (if_id_use_rs2),
        .i_id_ex_valid    (id_ex_valid),
        .i_id_ex_mem_read (id_ex_mem_read),
        .i_id_ex_rd       (id_ex_rd),
        .o_hit            (w_load_use_hit)
    );

    assign w_in_run        = (r_state == HZ_RUN);
    assign w_in_wait       = (r_state == HZ_MEM_WAIT);
    assign w_in_flush      = (r_state == HZ_FLUSH);
    assign w_flush_cnt_inc = r_flush_cnt + FLUSH_CNT_W'(1);

    // Priority chain: freeze > redirect > load-use; completion beats timeout
    assign w_timeout  = w_in_wait && !dmem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_freeze   = (w_in_run && mem_req && !dmem_ready) ||
                        (w_in_wait && !dmem_ready && !w_timeout);
    assign w_redirect = w_in_run && ex_redirect && !w_freeze;
    assign w_load_use = w_in_run && !w_freeze && !w_redirect && w_load_use_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HZ_RUN: begin
                if (w_freeze) begin
                    w_state_next = HZ_MEM_WAIT;
                end else if (w_redirect && (FLUSH_CYCLES > 1)) begin
                    w_state_next = HZ_FLUSH;
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready || w_timeout) begin
                    w_state_next = HZ_RUN;
                end
            end
            HZ_FLUSH: begin
                if (w_flush_cnt_inc == FLUSH_LAST) begin
                    w_state_next = HZ_RUN;
                end
            end
            default: w_state_next = HZ_RUN;
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        hazard_stall = 1'b0;
        hazard_flush = 1'b0;
        mem_freeze   = 1'b0;
        if (!reset) begin
            if (w_freeze) begin
                mem_freeze  = 1'b1;
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end else if (w_redirect) begin
                if_id_flush  = 1'b1;
                hazard_flush = 1'b1;
            end else if (w_in_flush) begin
                if_id_flush = 1'b1;
            end else if (w_load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                hazard_stall = 1'b1;
            end
        end
    end

    // Counters stay cleared outside their state, so entry always starts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_mem_timeout <= w_timeout;
            if (w_in_wait && !dmem_ready) begin
                r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
            end else if (!w_in_wait) begin
                r_wait_cnt <= '0;
            end
            if (w_in_flush) begin
                r_flush_cnt <= w_flush_cnt_inc;
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign ctrl_state  = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] r_perf_stall_cycles;
    logic [PERF_CNT_W-1:0] r_perf_flush_events;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall_cycles <= '0;
            r_perf_flush_events <= '0;
        end else begin
            if (pc_stall) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + PERF_CNT_W'(1);
            end
            if (w_redirect) begin
                r_perf_flush_events <= r_perf_flush_events + PERF_CNT_W'(1);
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_flush_events = r_perf_flush_events;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, checked
// every cycle against a behavioural model of access age, flush budget and bubble rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned FC = 3;
    localparam int unsigned MT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_id_valid;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic        if_id_use_rs1;
    logic        if_id_use_rs2;
    logic        id_ex_valid;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        dmem_ready;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        hazard_stall;
    logic        hazard_flush;
    logic        mem_freeze;
    logic        mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_id_valid       (if_id_valid),
        .if_id_rs1         (if_id_rs1),
        .if_id_rs2         (if_id_rs2),
        .if_id_use_rs1     (if_id_use_rs1),
        .if_id_use_rs2     (if_id_use_rs2),
        .id_ex_valid       (id_ex_valid),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_rd          (id_ex_rd),
        .ex_redirect       (ex_redirect),
        .mem_req           (mem_req),
        .dmem_ready        (dmem_ready),
        .pc_stall          (pc_stall),
        .if_id_stall       (if_id_stall),
        .if_id_flush       (if_id_flush),
        .hazard_stall      (hazard_stall),
        .hazard_flush      (hazard_flush),
        .mem_freeze        (mem_freeze),
        .mem_timeout       (mem_timeout),
        .ctrl_state        (ctrl_state),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: an outstanding access has an age in not-ready cycles; a redirect leaves a flush budget
    bit          m_waiting;
    int          m_age;
    int          m_flush_left;
    bit          m_tmo;
    int unsigned m_stall_cnt;
    int unsigned m_flush_evt;

    int n_freeze, n_iflush, n_hflush, n_hstall, n_pcstall, n_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_id_valid = 0; if_id_rs1 = 0; if_id_rs2 = 0; if_id_use_rs1 = 0; if_id_use_rs2 = 0;
        id_ex_valid = 0; id_ex_mem_read = 0; id_ex_rd = 0;
        ex_redirect = 0; mem_req = 0; dmem_ready = 0;
    endtask

    task automatic rnd_inputs();
        if_id_valid    = ($urandom_range(3) != 0);
        if_id_rs1      = 5'($urandom_range(3));
        if_id_rs2      = 5'($urandom_range(3));
        if_id_use_rs1  = $urandom_range(1) == 1;
        if_id_use_rs2  = $urandom_range(1) == 1;
        id_ex_valid    = ($urandom_range(3) != 0);
        id_ex_mem_read = $urandom_range(1) == 1;
        id_ex_rd       = 5'($urandom_range(3));
        ex_redirect    = ($urandom_range(7) == 0);
        mem_req        = ($urandom_range(3) == 0);
        dmem_ready     = ($urandom_range(3) == 0);
    endtask

    task automatic clr_counts();
        n_freeze = 0; n_iflush = 0; n_hflush = 0; n_hstall = 0; n_pcstall = 0; n_tmo = 0;
    endtask

    function automatic bit lu_dep();
        bit dep;
        dep = (if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd);
        return if_id_valid && id_ex_valid && id_ex_mem_read && (id_ex_rd != 0) && dep;
    endfunction

    // Check one cycle at the falling edge, then advance the model across the rising edge
    task automatic cycle();
        bit          e_freeze, e_redir, e_lu, e_flush_only, e_tmo_now;
        logic [1:0]  e_state;
        logic [31:0] e_ps, e_pf;
        @(negedge clk);
        e_freeze = 0; e_redir = 0; e_lu = 0; e_flush_only = 0; e_tmo_now = 0;
        e_state = m_waiting ? 2'd1 : ((m_flush_left > 0) ? 2'd2 : 2'd0);
        if (!reset) begin
            if (m_waiting) begin
                if (!dmem_ready) begin
                    if (m_age == int'(MT)) e_tmo_now = 1;
                    else e_freeze = 1;
                end
            end else if (m_flush_left > 0) e_flush_only = 1;
            else if (mem_req && !dmem_ready) e_freeze = 1;
            else if (ex_redirect) e_redir = 1;
            else if (lu_dep()) e_lu = 1;
        end
`ifdef HAZARD_PERF_CNT_EN
        e_ps = m_stall_cnt;
        e_pf = m_flush_evt;
`else
        e_ps = 0;
        e_pf = 0;
`endif
        chk("pc_stall",     32'(pc_stall),     32'(e_freeze | e_lu));
        chk("if_id_stall",  32'(if_id_stall),  32'(e_freeze | e_lu));
        chk("if_id_flush",  32'(if_id_flush),  32'(e_redir | e_flush_only));
        chk("hazard_stall", 32'(hazard_stall), 32'(e_lu));
        chk("hazard_flush", 32'(hazard_flush), 32'(e_redir));
        chk("mem_freeze",   32'(mem_freeze),   32'(e_freeze));
        chk("mem_timeout",  32'(mem_timeout),  32'(m_tmo));
        chk("ctrl_state",   32'(ctrl_state),   32'(e_state));
        chk("perf_stall",   perf_stall_cycles, e_ps);
        chk("perf_flush",   perf_flush_events, e_pf);
        n_freeze  += int'(mem_freeze);
        n_iflush  += int'(if_id_flush);
        n_hflush  += int'(hazard_flush);
        n_hstall  += int'(hazard_stall);
        n_pcstall += int'(pc_stall);
        n_tmo     += int'(mem_timeout);
        if (reset) begin
            m_waiting = 0; m_age = 0; m_flush_left = 0; m_tmo = 0;
            m_stall_cnt = 0; m_flush_evt = 0;
        end else begin
            m_tmo = e_tmo_now;
            if (m_waiting) begin
                if (dmem_ready || e_tmo_now) m_waiting = 0;
                else m_age++;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (e_freeze) begin
                m_waiting = 1;
                m_age = 1;
            end else if (e_redir) begin
                m_flush_left = int'(FC) - 1;
            end
            if (e_freeze || e_lu) m_stall_cnt++;
            if (e_redir) m_flush_evt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        m_waiting = 0; m_age = 0; m_flush_left = 0; m_tmo = 0; m_stall_cnt = 0; m_flush_evt = 0;
        clr_counts();
        repeat (2) @(posedge clk);
        #1;

        // Reset holds every control low whatever the inputs
        for (int i = 0; i < 3; i++) begin
            rnd_inputs();
            cycle();
        end
        reset = 0;
        idle();
        cycle();

        // Load-use bubble lasts exactly one cycle
        clr_counts();
        if_id_valid = 1; if_id_rs1 = 5; if_id_use_rs1 = 1;
        id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 5;
        cycle();
        id_ex_valid = 0; id_ex_mem_read = 0;
        cycle();
        chk("load_use_bubbles", 32'(n_hstall), 32'd1);

        // Load to x0 never stalls
        idle();
        clr_counts();
        if_id_valid = 1; if_id_use_rs1 = 1; if_id_rs1 = 0;
        id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 0;
        cycle();
        chk("x0_no_stall", 32'(n_pcstall), 32'd0);

        // Redirect: one ID flush, FC cycles of IF/ID flush
        idle();
        clr_counts();
        ex_redirect = 1;
        cycle();
        ex_redirect = 0;
        repeat (4) cycle();
        chk("redir_if_id_flush", 32'(n_iflush), 32'(FC));
        chk("redir_hazard_flush", 32'(n_hflush), 32'd1);

        // Memory wait of four not-ready cycles
        clr_counts();
        mem_req = 1;
        repeat (4) cycle();
        dmem_ready = 1;
        cycle();
        idle();
        cycle();
        chk("wait_freeze_cycles", 32'(n_freeze), 32'd4);

        // Timeout: MT frozen cycles, then a single pulse
        clr_counts();
        mem_req = 1;
        repeat (MT + 1) cycle();
        idle();
        repeat (2) cycle();
        chk("tmo_freeze_cycles", 32'(n_freeze), 32'(MT));
        chk("tmo_pulses", 32'(n_tmo), 32'd1);

        // Priority: freeze masks redirect and load-use; redirect then wins over load-use
        clr_counts();
        if_id_valid = 1; if_id_rs1 = 7; if_id_use_rs1 = 1;
        id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 7;
        ex_redirect = 1; mem_req = 1; dmem_ready = 0;
        repeat (2) cycle();
        chk("prio_freeze_only", 32'(n_hflush + n_hstall + n_iflush), 32'd0);
        dmem_ready = 1;
        cycle();
        mem_req = 0; dmem_ready = 0;
        cycle();
        ex_redirect = 0;
        repeat (2) cycle();
        idle();
        cycle();
        chk("prio_redirect_once", 32'(n_hflush), 32'd1);
        chk("prio_no_load_use", 32'(n_hstall), 32'd0);

        // Reset mid-wait and mid-flush return to RUN without a pulse
        mem_req = 1;
        repeat (3) cycle();
        reset = 1;
        cycle();
        reset = 0;
        idle();
        clr_counts();
        repeat (3) cycle();
        chk("rst_wait_no_pulse", 32'(n_tmo), 32'd0);
        ex_redirect = 1;
        cycle();
        ex_redirect = 0;
        reset = 1;
        cycle();
        reset = 0;
        clr_counts();
        cycle();
        chk("rst_flush_cleared", 32'(n_iflush), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rnd_inputs();
            reset = ($urandom_range(63) == 0);
            cycle();
        end
        reset = 0;
        idle();
        repeat (12) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
